// File: rtl/nes_controller_reader.sv
// Serial reader for an NES joypad: drives LATCH/PULSE, shifts in 8 active-low bits and
// presents them as an active-high parallel byte with a one-cycle valid strobe.
module nes_controller_reader #(
    parameter int unsigned CLK_DIV = 100,
    parameter int unsigned NUM_BTN = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       ctrl_data_i,
    output logic       ctrl_latch_o,
    output logic       ctrl_pulse_o,
    output logic [7:0] buttons_o,
    output logic       valid_o,
    output logic       busy_o
);

    localparam int unsigned CntW = $clog2(2 * CLK_DIV);
    localparam logic [CntW-1:0] PhaseLast = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0] LatchLast = CntW'(2 * CLK_DIV - 1);
    localparam logic [2:0] IdxLast = 3'(NUM_BTN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLatch,
        StRead,
        StPulseHi,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shadow_q, shadow_d;
    logic [7:0]      buttons_q, buttons_d;
    logic [1:0]      sync_q;
    logic            sync_data;

    // Pad data is asynchronous to clk; idle level of the line is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], ctrl_data_i};
        end
    end

    assign sync_data = sync_q[1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            buttons_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            buttons_q <= buttons_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CntW'(1);
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        buttons_d = buttons_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_i) begin
                    state_d = StLatch;
                    idx_d   = '0;
                end
            end
            StLatch: begin
                if (cnt_q == LatchLast) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end
            end
            StRead: begin
                if (cnt_q == PhaseLast) begin
                    shadow_d[idx_q] = ~sync_data;
                    cnt_d           = '0;
                    if (idx_q == IdxLast) begin
                        // Last bit merged straight into the visible result in the same edge.
                        buttons_d = shadow_d;
                        state_d   = StDone;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StPulseHi;
                    end
                end
            end
            StPulseHi: begin
                if (cnt_q == PhaseLast) begin
                    state_d = StRead;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    assign ctrl_latch_o = (state_q == StLatch);
    assign ctrl_pulse_o = (state_q == StPulseHi);
    assign valid_o      = (state_q == StDone);
    assign busy_o       = (state_q != StIdle);
    assign buttons_o    = buttons_q;

endmodule
